// File: rtl/obi_arb_pkg.sv
// Shared types and helpers for the OBI round-robin arbiter and its response FIFO.
// Build option: OBI_RR_ARBITER_FIXED_PRIO_EN (see obi_rr_arbiter.sv).
package obi_arb_pkg;

    // Bit count needed to index n entries, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Byte-enable width for a given data width.
    function automatic int unsigned be_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // Upper bound on NUM_PORTS; the port index type is sized from it.
    localparam int unsigned MAX_PORTS  = 64;
    localparam int unsigned PORT_IDX_W = clog2_min1(MAX_PORTS);

    typedef logic [PORT_IDX_W-1:0] port_idx_t;

endpackage

// File: rtl/obi_arb_resp_fifo.sv
// Synchronous FIFO of port indices that records grant order for response routing.
// Build option: none.
module obi_arb_resp_fifo
    import obi_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_c,
    output logic             empty_c,
    output logic [WIDTH-1:0] head_c
);

    localparam int unsigned PTR_W = clog2_min1(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_c  = (count == CNT_W'(DEPTH));
    assign empty_c = (count == '0);
    assign head_c  = mem[rd_ptr];
    assign do_push = push_i && !full_c;
    assign do_pop  = pop_i && !empty_c;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage; contents are only meaningful between push and pop, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/obi_rr_arbiter.sv
// N-to-1 OBI data-bus arbiter with in-order response routing and sticky error flag.
// Build option: define OBI_RR_ARBITER_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no rotating pointer); otherwise round-robin.
module obi_rr_arbiter
    import obi_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS       = 2,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned BE_WIDTH       = be_width(DATA_WIDTH)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_PORTS-1:0]            s_req_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] s_addr_i,
    input  logic [NUM_PORTS*BE_WIDTH-1:0]   s_be_i,
    input  logic [NUM_PORTS-1:0]            s_we_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_wdata_i,
    output logic [NUM_PORTS-1:0]            s_gnt_o,
    output logic [NUM_PORTS-1:0]            s_rvalid_o,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] s_rdata_o,
    output logic                            m_req_o,
    output logic [ADDR_WIDTH-1:0]           m_addr_o,
    output logic [BE_WIDTH-1:0]             m_be_o,
    output logic                            m_we_o,
    output logic [DATA_WIDTH-1:0]           m_wdata_o,
    input  logic                            m_gnt_i,
    input  logic                            m_rvalid_i,
    input  logic [DATA_WIDTH-1:0]           m_rdata_i,
    output logic                            err_o
);

    logic      any_req;
    logic      found;
    logic      transfer;
    logic      fifo_full;
    logic      fifo_empty;
    port_idx_t winner;
    port_idx_t head;

`ifndef OBI_RR_ARBITER_FIXED_PRIO_EN
    port_idx_t rr_ptr;
`endif

    assign any_req  = |s_req_i;
    // Reset gates the request so nothing is offered while state is being cleared.
    assign m_req_o  = any_req && !fifo_full && !rst_i;
    assign transfer = m_req_o && m_gnt_i;

    // Winner select: first requester at/after the pointer, then wrap to the bottom.
    always_comb begin
        winner = '0;
        found  = 1'b0;
`ifndef OBI_RR_ARBITER_FIXED_PRIO_EN
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (!found && s_req_i[j] && (port_idx_t'(j) >= rr_ptr)) begin
                winner = port_idx_t'(j);
                found  = 1'b1;
            end
        end
`endif
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (!found && s_req_i[j]) begin
                winner = port_idx_t'(j);
                found  = 1'b1;
            end
        end
    end

    // Route the winner's payload to the master; all zero when nobody requests.
    always_comb begin
        m_addr_o  = '0;
        m_be_o    = '0;
        m_we_o    = 1'b0;
        m_wdata_o = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (any_req && (winner == port_idx_t'(j))) begin
                m_addr_o  = s_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
                m_be_o    = s_be_i[j*BE_WIDTH +: BE_WIDTH];
                m_we_o    = s_we_i[j];
                m_wdata_o = s_wdata_i[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Per-port grant and response strobes.
    always_comb begin
        s_gnt_o    = '0;
        s_rvalid_o = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            s_gnt_o[j]    = transfer && (winner == port_idx_t'(j));
            s_rvalid_o[j] = m_rvalid_i && !fifo_empty && !rst_i && (head == port_idx_t'(j));
        end
    end

    assign s_rdata_o = {NUM_PORTS{m_rdata_i}};

`ifndef OBI_RR_ARBITER_FIXED_PRIO_EN
    // Advance the rotation past the port that just transferred.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
        end else if (transfer) begin
            rr_ptr <= (winner == port_idx_t'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;
        end
    end
`endif

    // Sticky flag for a response that has no matching outstanding transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (m_rvalid_i && fifo_empty) begin
            err_o <= 1'b1;
        end
    end

    obi_arb_resp_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (PORT_IDX_W)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (transfer),
        .data_i  (winner),
        .pop_i   (m_rvalid_i),
        .full_c  (fifo_full),
        .empty_c (fifo_empty),
        .head_c  (head)
    );

endmodule
